// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns MEM-stage requests into single Wishbone-style
// data-port transfers with lane steering, load extension and a bus timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_wr_en,
   output logic [31:0] wb_addr,
   output logic [31:0] wb_wr_data,
   output logic [3:0]  wb_sel,
   input  logic        wb_ack,
   input  logic        wb_stall,
   input  logic [31:0] wb_rd_data
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT_ACK, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [1:0]    off_q, off_d;
   logic          wb_cyc_q, wb_cyc_d, wb_stb_q, wb_stb_d, wb_wr_en_q, wb_wr_en_d;
   logic [31:0]   wb_addr_q, wb_addr_d, wb_wr_data_q, wb_wr_data_d;
   logic [3:0]    wb_sel_q, wb_sel_d;
   logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, busy_q, busy_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          accept_s, legal_s, ack_done_s, expire_s, on_bus_s;

   function automatic logic is_legal(input logic wr, input logic [2:0] f3, input logic [1:0] a);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = ~a[0];
         3'b010:  ok = (a == 2'b00);
         3'b100:  ok = ~wr;
         3'b101:  ok = ~wr & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] a);
      logic [3:0] s;
      case (sz)
         2'b00:   s = 4'b0001 << a;
         2'b01:   s = 4'b0011 << {a[1], 1'b0};
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] r;
      case (sz)
         2'b00:   r = {4{d[7:0]}};
         2'b01:   r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
      logic [31:0] lane;
      logic [31:0] r;
      lane = d >> {a, 3'b000};
      case (f3)
         3'b000:  r = {{24{lane[7]}}, lane[7:0]};
         3'b001:  r = {{16{lane[15]}}, lane[15:0]};
         3'b010:  r = d;
         3'b100:  r = {24'h0, lane[7:0]};
         3'b101:  r = {16'h0, lane[15:0]};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   assign req_ready  = (state_q == S_IDLE) & ~rst;
   assign accept_s   = req_valid & req_ready;
   assign legal_s    = is_legal(req_wr, req_funct3, req_addr[1:0]);
   assign on_bus_s   = (state_q == S_STROBE) | (state_q == S_WAIT_ACK);
   // Ack is only honoured once the strobe has been taken (stall low) or while waiting.
   assign ack_done_s = wb_ack & (((state_q == S_STROBE) & ~wb_stall) | (state_q == S_WAIT_ACK));
   assign expire_s   = on_bus_s & (cnt_q == CNT_LAST);

   // State and registered-output register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;       cnt_q <= '0;            funct3_q <= 3'b000;  off_q <= 2'b00;
         wb_cyc_q <= 1'b0;        wb_stb_q <= 1'b0;       wb_wr_en_q <= 1'b0;
         wb_addr_q <= 32'h0;      wb_wr_data_q <= 32'h0;  wb_sel_q <= 4'b0000;
         rsp_valid_q <= 1'b0;     rsp_err_q <= 1'b0;      rsp_rdata_q <= 32'h0; busy_q <= 1'b0;
      end else begin
         state_q <= state_d;      cnt_q <= cnt_d;         funct3_q <= funct3_d; off_q <= off_d;
         wb_cyc_q <= wb_cyc_d;    wb_stb_q <= wb_stb_d;   wb_wr_en_q <= wb_wr_en_d;
         wb_addr_q <= wb_addr_d;  wb_wr_data_q <= wb_wr_data_d; wb_sel_q <= wb_sel_d;
         rsp_valid_q <= rsp_valid_d; rsp_err_q <= rsp_err_d; rsp_rdata_q <= rsp_rdata_d;
         busy_q <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = legal_s ? S_STROBE : S_DONE;
            else          state_d = S_IDLE;
         end
         S_STROBE: begin
            if (ack_done_s || expire_s) state_d = S_DONE;
            else if (!wb_stall)         state_d = S_WAIT_ACK;
            else                        state_d = S_STROBE;
         end
         S_WAIT_ACK: begin
            if (ack_done_s || expire_s) state_d = S_DONE;
            else                        state_d = S_WAIT_ACK;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      cnt_d = cnt_q;           funct3_d = funct3_q;      off_d = off_q;
      wb_cyc_d = wb_cyc_q;     wb_stb_d = wb_stb_q;      wb_wr_en_d = wb_wr_en_q;
      wb_addr_d = wb_addr_q;   wb_wr_data_d = wb_wr_data_q; wb_sel_d = wb_sel_q;
      rsp_valid_d = 1'b0;      rsp_err_d = 1'b0;         rsp_rdata_d = 32'h0;
      busy_d = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               cnt_d    = '0;
               funct3_d = req_funct3;
               off_d    = req_addr[1:0];
               if (legal_s) begin
                  wb_cyc_d     = 1'b1;
                  wb_stb_d     = 1'b1;
                  wb_wr_en_d   = req_wr;
                  wb_addr_d    = {req_addr[31:2], 2'b00};
                  wb_sel_d     = lane_sel(req_funct3[1:0], req_addr[1:0]);
                  wb_wr_data_d = req_wr ? replicate(req_funct3[1:0], req_wdata) : 32'h0;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_STROBE, S_WAIT_ACK: begin
            cnt_d = cnt_q + CNT_ONE;
            if (state_d == S_DONE) begin
               wb_cyc_d = 1'b0;      wb_stb_d = 1'b0;         wb_wr_en_d = 1'b0;
               wb_addr_d = 32'h0;    wb_wr_data_d = 32'h0;    wb_sel_d = 4'b0000;
               rsp_valid_d = 1'b1;
               if (ack_done_s) begin
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = wb_wr_en_q ? 32'h0 : load_extract(funct3_q, off_q, wb_rd_data);
               end else begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end
            end else if (state_d == S_WAIT_ACK) begin
               wb_stb_d = 1'b0;
            end else begin
               wb_stb_d = wb_stb_q;
            end
         end
         S_DONE: cnt_d = cnt_q;
         default: begin
            wb_cyc_d = 1'b0;
            wb_stb_d = 1'b0;
         end
      endcase
   end

   assign wb_cyc     = wb_cyc_q;
   assign wb_stb     = wb_stb_q;
   assign wb_wr_en   = wb_wr_en_q;
   assign wb_addr    = wb_addr_q;
   assign wb_wr_data = wb_wr_data_q;
   assign wb_sel     = wb_sel_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses against a byte-level reference model of the RV32I access rules.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_wr = 1'b0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic [2:0]  req_funct3 = 3'b000;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        wb_cyc, wb_stb, wb_wr_en;
   logic [31:0] wb_addr, wb_wr_data;
   logic [3:0]  wb_sel;
   logic        wb_ack = 1'b0, wb_stall = 1'b0;
   logic [31:0] wb_rd_data = 32'h0;

   int checks = 0;
   int failures = 0;

   load_store_unit #(.TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
      .wb_wr_data(wb_wr_data), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_stall(wb_stall),
      .wb_rd_data(wb_rd_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int ref_bytes(input bit [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      if (f3 == 3'd2) return 4;
      return 0;
   endfunction

   function automatic bit ref_legal(input bit wr, input bit [2:0] f3, input bit [31:0] a);
      int nb;
      nb = ref_bytes(f3);
      if (nb == 0) return 1'b0;
      if (wr && f3 > 3'd3) return 1'b0;
      return (a % nb) == 0;
   endfunction

   function automatic bit [3:0] ref_sel(input bit [2:0] f3, input bit [31:0] a);
      bit [3:0] s;
      int off, nb;
      s = 4'b0000; off = int'(a % 4); nb = ref_bytes(f3);
      for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
      return s;
   endfunction

   function automatic bit [31:0] ref_wdata(input bit [2:0] f3, input bit [31:0] wd);
      bit [31:0] r;
      int nb;
      nb = ref_bytes(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] word);
      bit [63:0] v, mask;
      int nb;
      nb   = ref_bytes(f3);
      mask = (64'd1 << (8*nb)) - 64'd1;
      v    = ({32'h0, word} >> (8*(a % 4))) & mask;
      if (f3 < 3'd4 && v[8*nb-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   // One complete access: request, optional stall cycles, ack after ack_dly cycles (0 = with strobe).
   task automatic run_access(input bit wr, input bit [31:0] a, input bit [31:0] wd, input bit [2:0] f3,
                             input int stall_n, input int ack_dly, input bit [31:0] word);
      logic [70:0] exp_bus, got_bus;
      logic [36:0] exp_rsp, got_rsp;
      bit [31:0]   exp_rd;
      bit          legal;
      legal   = ref_legal(wr, f3, a);
      exp_bus = {1'b1, 1'b1, wr, ref_sel(f3, a), a & 32'hFFFF_FFFC, wr ? ref_wdata(f3, wd) : 32'h0};
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL ready_before got=%b exp=1 addr=%h", req_ready, a);
      end
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
      step();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      if (!legal) begin
         got_rsp = {rsp_valid, rsp_err, rsp_rdata, wb_cyc, wb_stb, busy};
         exp_rsp = {1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
         checks++;
         if (got_rsp !== exp_rsp) begin
            failures++; $display("FAIL illegal_rsp got=%h exp=%h f3=%0d addr=%h wr=%0d", got_rsp, exp_rsp, f3, a, wr);
         end
      end else begin
         for (int i = 0; i <= stall_n; i++) begin
            got_bus = {wb_cyc, wb_stb, wb_wr_en, wb_sel, wb_addr, wb_wr_data};
            checks++;
            if (got_bus !== exp_bus) begin
               failures++; $display("FAIL strobe_bus cyc%0d got=%h exp=%h f3=%0d addr=%h", i, got_bus, exp_bus, f3, a);
            end
            if (i < stall_n) begin
               wb_stall = 1'b1;
               step();
            end
         end
         wb_stall = 1'b0; wb_ack = (ack_dly == 0); wb_rd_data = (ack_dly == 0) ? word : $urandom;
         step();
         if (ack_dly > 0) begin
            checks++;
            if ({wb_cyc, wb_stb, rsp_valid} !== 3'b100) begin
               failures++; $display("FAIL wait_ack_bus got=%b exp=100", {wb_cyc, wb_stb, rsp_valid});
            end
            wb_ack = 1'b0;
            for (int i = 1; i < ack_dly; i++) step();
            wb_ack = 1'b1; wb_rd_data = word;
            step();
         end
         wb_ack = 1'b0; wb_rd_data = $urandom;
         exp_rd  = wr ? 32'h0 : ref_load(f3, a, word);
         got_rsp = {rsp_valid, rsp_err, rsp_rdata, wb_cyc, wb_stb, busy};
         exp_rsp = {1'b1, 1'b0, exp_rd, 1'b0, 1'b0, 1'b1};
         checks++;
         if (got_rsp !== exp_rsp) begin
            failures++; $display("FAIL done_rsp got=%h exp=%h f3=%0d addr=%h word=%h", got_rsp, exp_rsp, f3, a, word);
         end
      end
      step();
      checks++;
      if ({rsp_valid, busy, req_ready} !== 3'b001) begin
         failures++; $display("FAIL back_to_idle got=%b exp=001", {rsp_valid, busy, req_ready});
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [106:0] outs;
      rst = 1'b1;
      repeat (3) step();
      outs = {wb_cyc, wb_stb, wb_wr_en, wb_sel, wb_addr, wb_wr_data, rsp_valid, rsp_err, rsp_rdata, busy, req_ready};
      checks++;
      if (outs !== 107'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
      wb_ack = 1'b1;
      repeat (2) step();
      wb_ack = 1'b0;
      checks++;
      if ({rsp_valid, busy, wb_cyc} !== 3'b000) begin
         failures++; $display("FAIL idle_ack_ignored got=%b exp=000", {rsp_valid, busy, wb_cyc});
      end
   endtask

   task automatic test_directed();
      run_access(1'b0, 32'h0000_0008, 32'h0, 3'b010, 0, 1, 32'h8765_4321);  // LW
      run_access(1'b0, 32'h0000_0007, 32'h0, 3'b000, 0, 1, 32'h8012_3456);  // LB
      run_access(1'b0, 32'h0000_0007, 32'h0, 3'b100, 0, 1, 32'h8012_3456);  // LBU
      run_access(1'b1, 32'h0000_0006, 32'h1234_ABCD, 3'b001, 0, 1, 32'h0);  // SH
      run_access(1'b0, 32'h0000_0002, 32'h0, 3'b010, 0, 1, 32'h0);          // misaligned LW
      run_access(1'b1, 32'h0000_0010, 32'h5555_AAAA, 3'b100, 0, 1, 32'h0);  // store funct3=100
      run_access(1'b0, 32'h0000_0102, 32'h0, 3'b101, 0, 0, 32'hF00D_9ABC);  // LHU, ack with strobe
   endtask

   task automatic test_timeout();
      logic [70:0] exp_bus, got_bus;
      int cyc_n;
      bit done;
      exp_bus = {1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_0040, 32'h0};
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_0040; req_funct3 = 3'b010;
      step();
      req_valid = 1'b0; wb_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         got_bus = {wb_cyc, wb_stb, wb_wr_en, wb_sel, wb_addr, wb_wr_data};
         checks++;
         if (got_bus !== exp_bus) begin
            failures++; $display("FAIL stall_stable cyc%0d got=%h exp=%h", i, got_bus, exp_bus);
         end
         if (i < 3) step();
      end
      wb_stall = 1'b0; wb_ack = 1'b0;
      cyc_n = 4; done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         step();
         if (rsp_valid) done = 1'b1;
         else if (wb_cyc) cyc_n++;
      end
      checks++;
      if (!done) begin failures++; $display("FAIL timeout_rsp got=none exp=rsp_valid within 40 cycles"); end
      checks++;
      if (cyc_n != 15) begin failures++; $display("FAIL timeout_cycles got=%0d exp=15", cyc_n); end
      checks++;
      if ({rsp_err, rsp_rdata, wb_cyc, wb_stb} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
         failures++; $display("FAIL timeout_err got=%h exp=%h", {rsp_err, rsp_rdata, wb_cyc, wb_stb}, {1'b1, 32'h0, 2'b00});
      end
      step();
      checks++;
      if ({rsp_valid, busy, req_ready} !== 3'b001) begin
         failures++; $display("FAIL timeout_idle got=%b exp=001", {rsp_valid, busy, req_ready});
      end
   endtask

   task automatic test_reset_mid();
      logic [106:0] outs;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_0020; req_funct3 = 3'b010;
      step();
      req_valid = 1'b0;
      step();                           // strobe taken, now waiting for ack
      checks++;
      if ({wb_cyc, wb_stb} !== 2'b10) begin failures++; $display("FAIL mid_wait_ack got=%b exp=10", {wb_cyc, wb_stb}); end
      rst = 1'b1;
      step();
      outs = {wb_cyc, wb_stb, wb_wr_en, wb_sel, wb_addr, wb_wr_data, rsp_valid, rsp_err, rsp_rdata, busy, req_ready};
      checks++;
      if (outs !== 107'h0) begin failures++; $display("FAIL mid_reset_outputs got=%h exp=0", outs); end
      rst = 1'b0; wb_ack = 1'b1; wb_rd_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", req_ready); end
      step();
      wb_ack = 1'b0;
      checks++;
      if ({rsp_valid, rsp_rdata, busy, wb_cyc} !== 35'h0) begin
         failures++; $display("FAIL late_ack_ignored got=%h exp=0", {rsp_valid, rsp_rdata, busy, wb_cyc});
      end
   endtask

   task automatic test_back_to_back();
      run_access(1'b1, 32'h0000_0203, 32'h0000_00A5, 3'b000, 0, 1, 32'h0);
      run_access(1'b0, 32'h0000_0202, 32'h0, 3'b001, 0, 1, 32'h8001_7FFF);
   endtask

   task automatic test_random();
      bit [2:0] f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      for (int n = 0; n < 60; n++) begin
         run_access(1'($urandom), $urandom, $urandom, f3s[$urandom_range(7, 0) % 8 < 6 ? $urandom_range(4, 0) : $urandom_range(7, 5)],
                    $urandom_range(3, 0), $urandom_range(3, 0), $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, max bus cycles in STROBE+WAIT_ACK before abort.
REQ-002 Port: clk  in  1  clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  1  MEM-stage access request.
REQ-005 Port: req_ready  out  1  unit can accept request; high only in IDLE and rst low.
REQ-006 Port: req_wr  in  1  1 = store, 0 = load.
REQ-007 Port: req_addr  in  32  byte address.
REQ-008 Port: req_wdata  in  32  store data, right-aligned.
REQ-009 Port: req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 Port: rsp_err  out  1  misaligned, illegal funct3, or timeout; valid with rsp_valid.
REQ-013 Port: busy  out  1  high whenever state is not IDLE (pipeline stall).
REQ-014 Ports to main_memory data port: wb_cyc, wb_stb, wb_wr_en out 1; wb_addr out 32; wb_wr_data out 32; wb_sel out 4; wb_ack, wb_stall in 1; wb_rd_data in 32.

Function
REQ-015 FSM states IDLE, STROBE, WAIT_ACK, DONE; all outputs registered.
REQ-016 IDLE: request accepted at the edge where req_valid & req_ready; inputs captured; req_* ignored otherwise.
REQ-017 Legal combos: loads 000/001/010/100/101; stores 000/001/010; H requires addr[0]=0; W requires addr[1:0]=0.
REQ-018 Illegal/misaligned request: IDLE -> DONE, no bus activity, rsp_valid=1, rsp_err=1 in the cycle after acceptance.
REQ-019 Legal request: IDLE -> STROBE; cycle after acceptance wb_cyc=wb_stb=1, wb_addr={addr[31:2],2'b00}, wb_wr_en=req_wr.
REQ-020 wb_sel: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111; same for loads and stores.
REQ-021 wb_wr_data: B byte replicated x4; H halfword replicated x2; W unchanged; 0 for loads.
REQ-022 STROBE: stb held with stable addr/data/sel while wb_stall=1; at edge with wb_stall=0, stb drops -> WAIT_ACK, or -> DONE directly if wb_ack also sampled high.
REQ-023 WAIT_ACK: wb_cyc held, wb_stb=0; at edge with wb_ack=1 capture wb_rd_data, drop wb_cyc -> DONE.
REQ-024 DONE lasts exactly one cycle: rsp_valid=1, then -> IDLE; back-to-back request acceptable the following cycle.
REQ-025 Load extraction: lane = wb_rd_data >> (8*addr[1:0]); B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
REQ-026 Timeout counter clears on acceptance, increments each cycle in STROBE/WAIT_ACK; when count reaches TIMEOUT_CYCLES without ack: cyc/stb drop, -> DONE with rsp_err=1, rsp_rdata=0.
REQ-027 wb_ack sampled outside STROBE/WAIT_ACK is ignored.
REQ-028 Minimum load/store latency with zero-stall, next-cycle-ack memory: rsp_valid 3 cycles after acceptance edge.

Reset
REQ-029 rst at any edge: state IDLE, counter 0, wb_cyc/wb_stb/wb_wr_en/wb_sel/wb_addr/wb_wr_data/rsp_valid/rsp_err/rsp_rdata/busy all 0.
REQ-030 req_ready=0 while rst high; 1 in first cycle after rst low.
REQ-031 Reset mid-transaction aborts without rsp_valid; a late wb_ack is ignored.

Verification
REQ-032 LW addr 0x8, memory word 0x8765_4321 -> wb_sel=1111, rsp_rdata=0x8765_4321, rsp_err=0.
REQ-033 LB addr 0x7 then LBU addr 0x7, word 0x80xx_xxxx -> rsp_rdata 0xFFFF_FF80 then 0x0000_0080.
REQ-034 SH addr 0x6, wdata 0x1234_ABCD -> wb_sel=1100, wb_wr_data=0xABCD_ABCD, wb_wr_en=1, rsp_rdata=0.
REQ-035 LW addr 0x2 and store funct3=100 -> no wb_cyc, rsp_valid+rsp_err one cycle after acceptance.
REQ-036 wb_stall high 3 cycles -> stb/addr stable 4 cycles; ack never arrives -> rsp_err=1 after 15 bus cycles, wb_cyc low.
REQ-037 rst asserted in WAIT_ACK, ack next cycle -> no rsp_valid, all outputs 0, req_ready=1 after rst low.
